// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dds_pkg
// Brief    : Modulation codes, LFSR and sine-table geometry shared by the
//            symbol source and the modulation stage.
// Revision : 1.0 - initial release
// ============================================================================
package dds_pkg;

    typedef enum logic [3:0] {
        MOD_OOK  = 4'b0000,
        MOD_FSK  = 4'b0001,
        MOD_BPSK = 4'b0010,
        MOD_LFSR = 4'b0011
    } mod_e;

    localparam int PHASE_W = 32;

    localparam int                LFSR_W     = 5;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 5'b00001;
    localparam int                LFSR_TAP_A = 4;
    localparam int                LFSR_TAP_B = 2;

    localparam int LUT_AW    = 8;
    localparam int LUT_DEPTH = 256;
    localparam int LUT_DW    = 12;

    // x^5+x^3+1 Fibonacci step; a stuck all-zero register is recovered to the seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        logic [LFSR_W-1:0] nxt;
        if (q == '0) begin
            nxt = LFSR_SEED;
        end else begin
            nxt = {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_lut_256x12.sv
`default_nettype none
// ============================================================================
// Module   : sine_lut_256x12
// Brief    : 256-entry 12-bit signed sine table with registered read, built
//            from a 65-entry quarter wave.
// Revision : 1.0 - initial release
// ============================================================================
module sine_lut_256x12
    import dds_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [LUT_AW-1:0]        addr,
    output logic signed [LUT_DW-1:0] data
);

    localparam int QUARTER = LUT_DEPTH / 4;

    // round(2047*sin(2*pi*k/256)) for k = 0..64
    function automatic logic [LUT_DW-1:0] quarter_sin(input logic [6:0] k);
        logic [LUT_DW-1:0] v;
        v = 12'd0;
        case (k)
            7'd0:  v = 12'd0;    7'd1:  v = 12'd50;   7'd2:  v = 12'd100;  7'd3:  v = 12'd151;
            7'd4:  v = 12'd201;  7'd5:  v = 12'd251;  7'd6:  v = 12'd300;  7'd7:  v = 12'd350;
            7'd8:  v = 12'd399;  7'd9:  v = 12'd449;  7'd10: v = 12'd497;  7'd11: v = 12'd546;
            7'd12: v = 12'd594;  7'd13: v = 12'd642;  7'd14: v = 12'd690;  7'd15: v = 12'd737;
            7'd16: v = 12'd783;  7'd17: v = 12'd830;  7'd18: v = 12'd875;  7'd19: v = 12'd920;
            7'd20: v = 12'd965;  7'd21: v = 12'd1009; 7'd22: v = 12'd1052; 7'd23: v = 12'd1095;
            7'd24: v = 12'd1137; 7'd25: v = 12'd1179; 7'd26: v = 12'd1219; 7'd27: v = 12'd1259;
            7'd28: v = 12'd1299; 7'd29: v = 12'd1337; 7'd30: v = 12'd1375; 7'd31: v = 12'd1411;
            7'd32: v = 12'd1447; 7'd33: v = 12'd1483; 7'd34: v = 12'd1517; 7'd35: v = 12'd1550;
            7'd36: v = 12'd1582; 7'd37: v = 12'd1614; 7'd38: v = 12'd1644; 7'd39: v = 12'd1674;
            7'd40: v = 12'd1702; 7'd41: v = 12'd1729; 7'd42: v = 12'd1756; 7'd43: v = 12'd1781;
            7'd44: v = 12'd1805; 7'd45: v = 12'd1828; 7'd46: v = 12'd1850; 7'd47: v = 12'd1871;
            7'd48: v = 12'd1891; 7'd49: v = 12'd1910; 7'd50: v = 12'd1927; 7'd51: v = 12'd1944;
            7'd52: v = 12'd1959; 7'd53: v = 12'd1973; 7'd54: v = 12'd1986; 7'd55: v = 12'd1997;
            7'd56: v = 12'd2008; 7'd57: v = 12'd2017; 7'd58: v = 12'd2025; 7'd59: v = 12'd2032;
            7'd60: v = 12'd2037; 7'd61: v = 12'd2041; 7'd62: v = 12'd2045; 7'd63: v = 12'd2046;
            7'd64: v = 12'd2047;
            default: v = 12'd0;
        endcase
        return v;
    endfunction

    logic [1:0]               w_quad;
    logic [6:0]               w_idx;
    logic [LUT_DW-1:0]        w_mag;
    logic signed [LUT_DW-1:0] w_val;

    // Odd quadrants read the quarter wave backwards; the upper half is negated.
    always_comb begin
        w_quad = addr[LUT_AW-1:LUT_AW-2];
        w_idx  = {1'b0, addr[LUT_AW-3:0]};
        if (w_quad[0]) begin
            w_idx = 7'(QUARTER) - {1'b0, addr[LUT_AW-3:0]};
        end
        w_mag = quarter_sin(w_idx);
        w_val = w_quad[1] ? -$signed(w_mag) : $signed(w_mag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (en) begin
            data <= w_val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dds_symbol_source.sv
`default_nettype none
// ============================================================================
// Module   : dds_symbol_source
// Brief    : 32-bit phase-accumulator tone source with symbol timer and
//            5-bit PN data generator driving FSK tone selection.
// Revision : 1.0 - initial release
// ============================================================================
module dds_symbol_source
    import dds_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         modulation,
    input  logic [31:0]        tuning_word0,
    input  logic [31:0]        tuning_word1,
    input  logic [15:0]        symbol_period,
    output logic signed [11:0] dds_out,
    output logic               lfsr_mod,
    output logic               symbol_strobe
);

    logic [PHASE_W-1:0] r_phase;
    logic [15:0]        r_count;
    logic [LFSR_W-1:0]  r_lfsr;
    logic               r_strobe;

    logic [PHASE_W-1:0] w_inc;
    logic [15:0]        w_last;
    logic               w_wrap;

    // Only FSK steers the tone; BPSK, LFSR and unknown codes keep the mark tone here.
    always_comb begin
        w_inc = tuning_word0;
        if ((modulation == MOD_FSK) && r_lfsr[LFSR_W-1]) begin
            w_inc = tuning_word1;
        end
        w_last = (symbol_period == 16'd0) ? 16'd0 : symbol_period - 16'd1;
        w_wrap = (r_count >= w_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase  <= '0;
            r_count  <= '0;
            r_lfsr   <= LFSR_SEED;
            r_strobe <= 1'b0;
        end else if (enable) begin
            r_phase <= r_phase + w_inc;
            if (w_wrap) begin
                r_count  <= '0;
                r_lfsr   <= lfsr_next(r_lfsr);
                r_strobe <= 1'b1;
            end else begin
                r_count  <= r_count + 16'd1;
                r_strobe <= 1'b0;
            end
        end else begin
            r_strobe <= 1'b0;
        end
    end

    sine_lut_256x12 u_sine_lut (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .addr  (r_phase[PHASE_W-1:PHASE_W-LUT_AW]),
        .data  (dds_out)
    );

    assign lfsr_mod      = r_lfsr[LFSR_W-1];
    assign symbol_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_dds_symbol_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_symbol_source
// Brief    : Directed scoreboard bench for dds_symbol_source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_symbol_source;

    localparam int K_DDS = 0;
    localparam int K_STB = 1;
    localparam int K_MOD = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic [3:0]         modulation = 4'd0;
    logic [31:0]        tuning_word0 = 32'd0;
    logic [31:0]        tuning_word1 = 32'd0;
    logic [15:0]        symbol_period = 16'd0;
    logic signed [11:0] dds_out;
    logic               lfsr_mod;
    logic               symbol_strobe;

    typedef struct {
        int          cyc;
        int          kind;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   r0       = 0;

    // lfsr_mod after n advances from the seed, n = 0..30
    bit mseq [31] = '{0,0,0,0,1,0,0,1,0,1,1,0,0,1,1,1,1,1,0,0,0,1,1,0,1,1,1,0,1,0,1};

    // sine samples at phase index k, one period sweep
    int t2_k [10] = '{0, 16, 32, 64, 96, 128, 160, 192, 255, 256};
    int t2_v [10] = '{0, 783, 1447, 2047, 1447, 0, -1447, -2047, -50, 0};

    dds_symbol_source dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .modulation    (modulation),
        .tuning_word0  (tuning_word0),
        .tuning_word1  (tuning_word1),
        .symbol_period (symbol_period),
        .dds_out       (dds_out),
        .lfsr_mod      (lfsr_mod),
        .symbol_strobe (symbol_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic string kname(input int k);
        if (k == K_DDS) return "dds_out";
        if (k == K_STB) return "symbol_strobe";
        return "lfsr_mod";
    endfunction

    function automatic void push(input int c, input int k, input logic [11:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Monitor: every expectation due this cycle is popped and compared.
    always @(negedge clk) begin
        logic [11:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= edge_n) begin
                n_checks = n_checks + 1;
                act = 12'(dds_out);
                if (sb[i].kind == K_STB) act = {11'd0, symbol_strobe};
                if (sb[i].kind == K_MOD) act = {11'd0, lfsr_mod};
                if (sb[i].cyc < edge_n) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s@%0d: never sampled, required %0d",
                             kname(sb[i].kind), sb[i].cyc, $signed(sb[i].val));
                end else if (act !== sb[i].val) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s@%0d: actual %0d, required %0d",
                             kname(sb[i].kind), sb[i].cyc, $signed(act), $signed(sb[i].val));
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [3:0] m, input logic [15:0] p);
        reset  = 1'b1;
        enable = 1'b1;
        step(1);
        push(edge_n, K_DDS, 12'd0);
        push(edge_n, K_STB, 12'd0);
        push(edge_n, K_MOD, 12'd0);
        tuning_word0  = w0;
        tuning_word1  = w1;
        modulation    = m;
        symbol_period = p;
        reset         = 1'b0;
        r0            = edge_n;
    endtask

    initial begin
        step(1);

        // Single tone sweep and symbol timing with period 4
        start_run(32'h0100_0000, 32'h0, 4'd0, 16'd4);
        foreach (t2_k[i]) push(r0 + 1 + t2_k[i], K_DDS, 12'(t2_v[i]));
        push(r0 + 1,  K_STB, 12'd0);
        push(r0 + 3,  K_STB, 12'd0);
        push(r0 + 4,  K_STB, 12'd1);
        push(r0 + 4,  K_MOD, 12'd0);
        push(r0 + 5,  K_STB, 12'd0);
        push(r0 + 16, K_STB, 12'd1);
        push(r0 + 16, K_MOD, 12'd1);
        push(r0 + 17, K_MOD, 12'd1);
        push(r0 + 20, K_STB, 12'd1);
        push(r0 + 20, K_MOD, 12'd0);
        step(258);

        // Enable held low for 10 cycles mid-symbol
        start_run(32'h0100_0000, 32'h0, 4'd0, 16'd4);
        push(r0 + 6, K_DDS, 12'd251);
        step(6);
        enable = 1'b0;
        for (int e = r0 + 7; e <= r0 + 16; e++) begin
            push(e, K_DDS, 12'd251);
            push(e, K_STB, 12'd0);
            push(e, K_MOD, 12'd0);
        end
        step(10);
        enable = 1'b1;
        push(r0 + 17, K_DDS, 12'd300);
        push(r0 + 17, K_STB, 12'd0);
        push(r0 + 18, K_STB, 12'd1);
        push(r0 + 18, K_DDS, 12'd350);
        step(3);

        // FSK: step doubles one edge after lfsr_mod rises, back after it falls
        start_run(32'h0100_0000, 32'h0200_0000, 4'b0001, 16'd4);
        push(r0 + 16, K_MOD, 12'd1);
        push(r0 + 16, K_DDS, 12'd737);
        push(r0 + 17, K_DDS, 12'd783);
        push(r0 + 18, K_DDS, 12'd875);
        push(r0 + 19, K_DDS, 12'd965);
        push(r0 + 20, K_DDS, 12'd1052);
        push(r0 + 20, K_MOD, 12'd0);
        push(r0 + 21, K_DDS, 12'd1137);
        push(r0 + 22, K_DDS, 12'd1179);
        step(24);

        // Undefined modulation code keeps tuning_word0
        start_run(32'h0100_0000, 32'h0200_0000, 4'b0101, 16'd4);
        push(r0 + 17, K_DDS, 12'd783);
        push(r0 + 18, K_DDS, 12'd830);
        push(r0 + 19, K_DDS, 12'd875);
        push(r0 + 22, K_DDS, 12'd1009);
        step(24);

        // symbol_period 0: advance every cycle, full 31-state cycle and beyond
        start_run(32'h0, 32'h0, 4'd0, 16'd0);
        for (int m = 1; m <= 35; m++) begin
            push(r0 + m, K_STB, 12'd1);
            push(r0 + m, K_MOD, {11'd0, mseq[m % 31]});
        end
        step(36);

        // Reset pulse at phase index 100 with enable held high
        start_run(32'h0100_0000, 32'h0, 4'd0, 16'd7);
        push(r0 + 100, K_DDS, 12'd1337);
        push(r0 + 100, K_MOD, 12'd1);
        step(100);
        reset = 1'b1;
        push(r0 + 101, K_DDS, 12'd0);
        push(r0 + 101, K_STB, 12'd0);
        push(r0 + 101, K_MOD, 12'd0);
        step(1);
        reset = 1'b0;
        push(r0 + 102, K_DDS, 12'd0);
        push(r0 + 103, K_DDS, 12'd50);
        push(r0 + 104, K_DDS, 12'd100);
        push(r0 + 107, K_STB, 12'd0);
        push(r0 + 108, K_STB, 12'd1);
        step(10);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
